phase_angle_calc: RTL and testbench
===================================

// Module: phase_angle_calc
//
// PURPOSE
//   Downstream of the phase detector. Converts its raw count of workClk ticks between
//   CHA and CHB rising edges (diffCounter) and the matching signal period count
//   (periodCounter, same tick units) into a phase angle in 0.01-degree units:
//   phase = floor(diff * SCALE / period).
//   diffCounter is written in the workClk domain and is quasi-static, so every
//   conversion double-samples both inputs and only uses a stable pair.
//
// PARAMETERS
//   CNT_W     64     width of diffCounter / periodCounter
//   OUT_W     16     width of phase; must satisfy SCALE < 2**OUT_W
//   SCALE     36000  full-circle value (36000 = 360.00 deg)
//   RETRY_MAX 8      unstable-sample retries before a conversion is aborted
//
// PORTS
//   sysClk         in   1       sole clock; all state on its rising edge
//   sysRst         in   1       asynchronous reset, active-high
//   start          in   1       1-cycle conversion request; ignored while busy=1
//   diffCounter    in   CNT_W   phase-delay tick count (async domain, quasi-static)
//   periodCounter  in   CNT_W   period tick count (async domain, quasi-static)
//   busy           out  1       high from the cycle after start until done
//   done           out  1       1-cycle completion pulse (success or error)
//   error          out  1       qualifies done; held until the next accepted start
//   phase          out  OUT_W   last successful result; updated only on error-free done
//
// BEHAVIOUR
//   - Reset: busy=0, done=0, error=0, phase=0, retry count=0, FSM=IDLE. Reset in any
//     state aborts the conversion immediately; no done pulse is produced.
//   - FSM: IDLE -> SAMP_A -> SAMP_B -> CHECK -> DIV (OUT_W cycles) -> DONE -> IDLE.
//     IDLE: start=1 -> SAMP_A; busy=1 and error=0 from the next edge.
//     SAMP_A: register dA=diffCounter, pA=periodCounter.
//     SAMP_B: compare the live inputs with dA/pA. Mismatch: retry++, back to SAMP_A;
//       if retry reaches RETRY_MAX -> DONE with error=1.
//     CHECK: pA==0 or dA>=pA -> DONE with error=1. Otherwise load
//       num = dA*SCALE (CNT_W+OUT_W bits, exact, no overflow), q=0, k=OUT_W-1.
//     DIV: restoring step per cycle: if num >= (pA<<k) then num -= pA<<k, q[k]=1;
//       k-- each cycle; compare/subtract width CNT_W+OUT_W+1 bits.
//     DONE: done=1 for exactly one cycle, busy=0 on the same edge; phase=q if error=0,
//       phase unchanged if error=1; retry cleared; -> IDLE.
//   - Latency with no retries: done is high in the 4+OUT_W = 20th cycle after the
//     cycle in which start was high. Each retry adds 2 cycles.
//   - Rounding: truncation toward zero. Result range 0..SCALE-1.
//   - start arriving in the same cycle as done is ignored; start is accepted only in IDLE.
//   - Inputs are not required to hold after SAMP_B; later changes do not affect the result.
//
// TESTING
//   1. diff=250, period=1000, start -> done at cycle 20, error=0, phase=9000.
//   2. After test 1: period=0, start -> done at cycle 4, error=1, phase stays 9000.
//   3. diff=1000, period=1000 -> error=1; diff=999, period=1000 -> phase=35964.
//   4. diff=1,period=7 -> 5142; diff=2^63, period=2^64-1 -> 18000 (truncation, full width).
//   5. diff toggles once between SAMP_A/SAMP_B -> done at cycle 22, correct phase;
//      diff changes every cycle -> error=1 after 8 retries, phase unchanged.
//   6. sysRst mid-DIV -> busy=0, phase=0, no done; start while busy -> ignored, one done.

Source files
------------

// File: rtl/phase_angle_calc.sv
// Phase angle converter: floor(diff * SCALE / period) via a restoring divider.
// Both async counters are double-sampled until a stable pair is captured.
module phase_angle_calc #(
  parameter int CNT_W     = 64,
  parameter int OUT_W     = 16,
  parameter int SCALE     = 36000,
  parameter int RETRY_MAX = 8
) (
  input  logic             sysClk,
  input  logic             sysRst,
  input  logic             start,
  input  logic [CNT_W-1:0] diffCounter,
  input  logic [CNT_W-1:0] periodCounter,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [OUT_W-1:0] phase
);

  localparam int NW = CNT_W + OUT_W;
  localparam int KW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW = $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SAMP_A, SAMP_B, CHECK, DIV, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] d_a;
  logic [CNT_W-1:0] p_a;
  logic [NW-1:0]    num;
  logic [OUT_W-1:0] q;
  logic [KW-1:0]    k;
  logic [RW-1:0]    retry;

  logic [NW:0]      shifted;
  logic [NW:0]      rem;
  logic             ge;
  logic [NW-1:0]    num_nxt;
  logic [OUT_W-1:0] q_nxt;
  logic [RW-1:0]    retry_inc;
  logic             unstable;

  // One restoring-division step against the divisor aligned to bit k.
  always_comb begin
    shifted   = (NW+1)'(p_a) << k;
    ge        = {1'b0, num} >= shifted;
    rem       = {1'b0, num} - shifted;
    num_nxt   = ge ? rem[NW-1:0] : num;
    q_nxt     = q | (OUT_W'(ge) << k);
    retry_inc = retry + 1'b1;
    unstable  = (diffCounter != d_a) || (periodCounter != p_a);
  end

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      phase <= '0;
      retry <= '0;
      d_a   <= '0;
      p_a   <= '0;
      num   <= '0;
      q     <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SAMP_A;
            busy  <= 1'b1;
            error <= 1'b0;
          end
        end
        SAMP_A: begin
          d_a   <= diffCounter;
          p_a   <= periodCounter;
          state <= SAMP_B;
        end
        SAMP_B: begin
          if (unstable) begin
            retry <= retry_inc;
            if (retry_inc == RW'(RETRY_MAX)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= SAMP_A;
            end
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (p_a == '0 || d_a >= p_a) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            num   <= NW'(d_a) * NW'(SCALE);
            q     <= '0;
            k     <= KW'(OUT_W - 1);
            state <= DIV;
          end
        end
        DIV: begin
          num <= num_nxt;
          q   <= q_nxt;
          k   <= k - 1'b1;
          if (k == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            phase <= q_nxt;
          end
        end
        DONE: begin
          done  <= 1'b0;
          retry <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_angle_calc.sv
// Bench for phase_angle_calc: vector table, corner sequences and
// randomized conversions against a wide-arithmetic reference.
module tb_phase_angle_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] diff = '0;
  logic [63:0] period = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] phase;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  phase_angle_calc dut (
    .sysClk        (clk),
    .sysRst        (rst),
    .start         (start),
    .diffCounter   (diff),
    .periodCounter (period),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .phase         (phase)
  );

  typedef struct {
    logic [63:0] d;
    logic [63:0] p;
    logic        e;
    logic [15:0] ph;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_phase(input logic [63:0] d,
                                            input logic [63:0] p);
    logic [127:0] n;
    n = {64'd0, d} * 128'd36000;
    return 16'(n / {64'd0, p});
  endfunction

  // mode 0 plain, 1 diff changes once in cycle 2, 2 diff changes
  // every cycle, 3 extra start pulses while busy and on the done cycle
  task automatic conv(input logic [63:0] d, input logic [63:0] p,
                      input logic [63:0] d2, input int mode,
                      output int lat, output logic e,
                      output logic [15:0] ph, output int nd);
    lat = -1;
    e   = 1'b0;
    ph  = '0;
    nd  = 0;
    @(posedge clk); #1;
    diff   = d;
    period = p;
    start  = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = n;
          e   = error;
          ph  = phase;
          chk("busy_low_at_done", 64'(busy), 64'd0);
        end
      end
      start = (mode == 3) && (n == 5 || n == 20);
      if (mode == 1 && n == 2) diff = d2;
      if (mode == 2) diff = diff + 64'd1;
      if (lat >= 0 && mode != 3) break;
    end
    start = 1'b0;
  endtask

  task automatic check_conv(input string name, input logic [63:0] d,
                            input logic [63:0] p, input logic [63:0] d2,
                            input int mode, input logic ee,
                            input logic [15:0] eph, input int elat);
    int          lat;
    int          nd;
    logic        e;
    logic [15:0] ph;
    conv(d, p, d2, mode, lat, e, ph, nd);
    chk({name, "_latency"}, 64'(lat), 64'(elat));
    chk({name, "_error"}, 64'(e), 64'(ee));
    chk({name, "_phase"}, 64'(ph), 64'(eph));
    if (mode == 3) chk({name, "_done_count"}, 64'(nd), 64'd1);
    @(posedge clk); #1;
    chk({name, "_error_held"}, 64'(error), 64'(ee));
    chk({name, "_done_low"}, 64'(done), 64'd0);
  endtask

  logic [15:0] model_ph;
  int          ndone;

  initial begin
    tbl[0] = '{64'd250, 64'd1000, 1'b0, 16'd9000, 20};
    tbl[1] = '{64'd250, 64'd0, 1'b1, 16'd9000, 4};
    tbl[2] = '{64'd1000, 64'd1000, 1'b1, 16'd9000, 4};
    tbl[3] = '{64'd999, 64'd1000, 1'b0, 16'd35964, 20};
    tbl[4] = '{64'd1, 64'd7, 1'b0, 16'd5142, 20};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 16'd18000, 20};
    tbl[6] = '{64'd0, 64'd5, 1'b0, 16'd0, 20};
    tbl[7] = '{64'd5, 64'd3, 1'b1, 16'd0, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_phase", 64'(phase), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      check_conv($sformatf("vec%0d", i), tbl[i].d, tbl[i].p, 64'd0, 0,
                 tbl[i].e, tbl[i].ph, tbl[i].lat);

    // single unstable sample costs one retry: 3*36000/7 = 15428
    check_conv("toggle_once", 64'd1, 64'd7, 64'd3, 1, 1'b0, 16'd15428, 22);
    check_conv("always_moving", 64'd2, 64'd1000, 64'd0, 2, 1'b1,
               16'd15428, 17);
    check_conv("start_while_busy", 64'd999, 64'd1000, 64'd0, 3, 1'b0,
               16'd35964, 20);

    // reset in the middle of the divide
    @(posedge clk); #1;
    diff   = 64'd250;
    period = 64'd1000;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_phase", 64'(phase), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    chk("midrst_idle", 64'(busy), 64'd0);

    model_ph = '0;
    for (int i = 0; i < 30; i++) begin
      logic [63:0] d;
      logic [63:0] p;
      logic        ee;
      p = {$urandom, $urandom};
      if (i % 7 == 3) p = 64'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0 && p != 0) d = d % p;
      ee = (p == 0) || (d >= p);
      if (!ee) model_ph = ref_phase(d, p);
      check_conv($sformatf("rnd%0d", i), d, p, 64'd0, 0, ee, model_ph,
                 ee ? 4 : 20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
